// File: rtl/xdom_pkg.sv
// xdom_pkg: FSM state types and default synchronizer depth shared by the
// cross-domain data receiver and its helpers.
package xdom_pkg;
    typedef enum logic [1:0] {X_IDLE, X_REQ, X_DONE} xstate_e;
    typedef enum logic {O_IDLE, O_ACK} ostate_e;
    localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/xdom_sync.sv
// xdom_sync: STAGES-deep asynchronously reset flop chain for single-bit crossings.
module xdom_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    always_ff @(posedge clk or posedge rst)
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/xdom_data_receiver.sv
// xdom_data_receiver: four-phase req/ack word transfer from xdom into odom.
// Define XDOM_DATA_RECEIVER_DROP_CNT_EN to add the saturating odom_drop_cnt_o port.
module xdom_data_receiver
    import xdom_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              odom_clk_i,
    input  logic              grst_i,
    input  logic              xdom_clk_i,
    input  logic              xdom_valid_i,
    input  logic [DATA_W-1:0] xdom_data_i,
    output logic              xdom_busy_o,
    output logic              xdom_err_o,
    output logic              odom_valid_o,
    output logic [DATA_W-1:0] odom_data_o,
`ifdef XDOM_DATA_RECEIVER_DROP_CNT_EN
    output logic [7:0]        odom_drop_cnt_o,
`endif
    input  logic              odom_ready_i
);
    xstate_e           xst_q, xst_d;
    ostate_e           ost_q, ost_d;
    logic              req_q, req_d, ack_q, ack_d, err_q, err_d, valid_q, valid_d;
    logic              req_s, ack_s;
    logic [DATA_W-1:0] hold_q, hold_d, data_q, data_d;

    xdom_sync #(.STAGES(SYNC_STAGES)) u_req_sync (.clk(odom_clk_i), .rst(grst_i), .d(req_q), .q(req_s));
    xdom_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (.clk(xdom_clk_i), .rst(grst_i), .d(ack_q), .q(ack_s));

    // hold_q only moves in X_IDLE, so odom can read it directly once req is seen
    always_comb begin
        xst_d  = xst_q;
        req_d  = req_q;
        hold_d = hold_q;
        err_d  = xdom_valid_i && xst_q != X_IDLE;
        case (xst_q)
            X_IDLE: if (xdom_valid_i) begin
                xst_d  = X_REQ;
                req_d  = 1'b1;
                hold_d = xdom_data_i;
            end
            X_REQ: if (ack_s) begin
                xst_d = X_DONE;
                req_d = 1'b0;
            end
            X_DONE:  xst_d = ack_s ? X_DONE : X_IDLE;
            default: xst_d = X_IDLE;
        endcase
    end

    always_ff @(posedge xdom_clk_i or posedge grst_i)
        if (grst_i) begin
            xst_q  <= X_IDLE;
            req_q  <= 1'b0;
            hold_q <= '0;
            err_q  <= 1'b0;
        end else begin
            xst_q  <= xst_d;
            req_q  <= req_d;
            hold_q <= hold_d;
            err_q  <= err_d;
        end

    // a word is only taken when the buffer is free after this edge's consume
    always_comb begin
        ost_d   = ost_q;
        ack_d   = ack_q;
        data_d  = data_q;
        valid_d = valid_q && !odom_ready_i;
        case (ost_q)
            O_IDLE: if (req_s && !valid_d) begin
                ost_d   = O_ACK;
                ack_d   = 1'b1;
                valid_d = 1'b1;
                data_d  = hold_q;
            end
            O_ACK: if (!req_s) begin
                ost_d = O_IDLE;
                ack_d = 1'b0;
            end
            default: ost_d = O_IDLE;
        endcase
    end

    always_ff @(posedge odom_clk_i or posedge grst_i)
        if (grst_i) begin
            ost_q   <= O_IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            ost_q   <= ost_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end

    assign xdom_busy_o  = xst_q != X_IDLE;
    assign xdom_err_o   = err_q;
    assign odom_valid_o = valid_q;
    assign odom_data_o  = data_q;

`ifdef XDOM_DATA_RECEIVER_DROP_CNT_EN
    logic       tgl_q, tgl_d, tgl_s, tgl_p_q, tgl_p_d;
    logic [7:0] cnt_q, cnt_d;

    xdom_sync #(.STAGES(SYNC_STAGES)) u_tgl_sync (.clk(odom_clk_i), .rst(grst_i), .d(tgl_q), .q(tgl_s));

    always_comb begin
        tgl_d   = tgl_q ^ err_q;
        tgl_p_d = tgl_s;
        cnt_d   = (tgl_s != tgl_p_q && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge xdom_clk_i or posedge grst_i)
        if (grst_i) tgl_q <= 1'b0;
        else        tgl_q <= tgl_d;

    always_ff @(posedge odom_clk_i or posedge grst_i)
        if (grst_i) begin
            tgl_p_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            tgl_p_q <= tgl_p_d;
            cnt_q   <= cnt_d;
        end

    assign odom_drop_cnt_o = cnt_q;
`endif
endmodule

// File: tb/tb_xdom_data_receiver.sv
// tb_xdom_data_receiver: directed vector table, hand sequences and a randomized
// scoreboard run (clocks swapped) for xdom_data_receiver.
module tb_xdom_data_receiver;
    localparam int SS = 2;

    logic        odom_clk, xdom_clk, grst, xvalid, ready, busy, err, ovalid;
    logic [31:0] xdata, odata;
    logic [7:0]  dcnt;
    int          oh = 50, xh = 135;
    int          errors = 0, checks = 0, n_deliv = 0, n_err = 0, oedges = 0;
    logic [31:0] last_data = 0;
    logic        rnd_mode = 0;

    typedef struct {logic [31:0] d; logic lat; int snap;} word_t;
    word_t exp_q[$];

    typedef struct {logic [31:0] d; int drops; logic [31:0] exp_d; int exp_err;} vec_t;
    vec_t tv[5];

    xdom_data_receiver #(.DATA_W(32), .SYNC_STAGES(SS)) dut (
        .odom_clk_i     (odom_clk),
        .grst_i         (grst),
        .xdom_clk_i     (xdom_clk),
        .xdom_valid_i   (xvalid),
        .xdom_data_i    (xdata),
        .xdom_busy_o    (busy),
        .xdom_err_o     (err),
        .odom_valid_o   (ovalid),
        .odom_data_o    (odata),
`ifdef XDOM_DATA_RECEIVER_DROP_CNT_EN
        .odom_drop_cnt_o(dcnt),
`endif
        .odom_ready_i   (ready)
    );

`ifndef XDOM_DATA_RECEIVER_DROP_CNT_EN
    assign dcnt = 8'd0;
`endif

    // edges of the two clocks never coincide: odom edges are 0 mod 5, xdom 3 mod 5
    initial begin odom_clk = 0; forever #(oh) odom_clk = ~odom_clk; end
    initial begin xdom_clk = 0; #3; forever #(xh) xdom_clk = ~xdom_clk; end

    always @(posedge odom_clk) oedges++;
    always @(negedge xdom_clk) if (!grst && err) n_err++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge odom_clk) begin
        if (!grst && ovalid && ready) begin
            n_deliv++;
            last_data = odata;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious delivery: got %0h expected no word", odata);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                chk("scoreboard data", odata, w.d);
                if (w.lat) begin
                    checks++;
                    if (oedges - w.snap < SS + 1 || oedges - w.snap > SS + 2) begin
                        errors++;
                        $display("FAIL latency: got %0d odom edges expected %0d..%0d", oedges - w.snap, SS + 1, SS + 2);
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge odom_clk); #1;
        if (rnd_mode) ready = 1'($urandom_range(0, 1));
    end

    task automatic set_ready(input logic v);
        @(posedge odom_clk); #1;
        ready = v;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(posedge xdom_clk); #1;
        while (busy && t < 400) begin @(posedge xdom_clk); #1; t++; end
        if (busy) begin
            checks++; errors++;
            $display("FAIL busy timeout: got busy=1 expected 0");
        end
    endtask

    task automatic send(input logic [31:0] d, input logic lat);
        wait_idle();
        xvalid = 1; xdata = d;
        @(posedge xdom_clk);
        exp_q.push_back('{d: d, lat: lat, snap: oedges});
        #1 xvalid = 0; xdata = $urandom;
    endtask

    task automatic drop();
        @(posedge xdom_clk); #1;
        chk("busy before drop", 32'(busy), 32'd1);
        xvalid = 1; xdata = $urandom;
        @(posedge xdom_clk); #1;
        xvalid = 0;
    endtask

    task automatic wait_deliv(input int n);
        int t = 0;
        while (n_deliv < n && t < 3000) begin @(negedge odom_clk); t++; end
        if (n_deliv < n) begin
            checks++; errors++;
            $display("FAIL delivery timeout: got %0d words expected %0d", n_deliv, n);
        end
    endtask

    initial begin
        int k0, e0, drops_total, exp_drops;
        drops_total = 0;
        tv[0] = '{32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
        tv[1] = '{32'hCAFEF00D, 2, 32'hCAFEF00D, 2};
        tv[2] = '{32'h00000000, 0, 32'h00000000, 0};
        tv[3] = '{32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1};
        tv[4] = '{32'h5A5AA5A5, 0, 32'h5A5AA5A5, 0};

        grst = 1; xvalid = 0; xdata = 0; ready = 1;
        repeat (3) @(posedge odom_clk);
        #1;
        chk("reset busy", 32'(busy), 0);
        chk("reset err", 32'(err), 0);
        chk("reset valid", 32'(ovalid), 0);
        chk("reset data", odata, 0);
        chk("reset drop cnt", 32'(dcnt), 0);
        grst = 0;

        for (int i = 0; i < 5; i++) begin
            k0 = n_deliv; e0 = n_err;
            send(tv[i].d, 1);
            for (int j = 0; j < tv[i].drops; j++) drop();
            drops_total += tv[i].drops;
            wait_deliv(k0 + 1);
            wait_idle();
            repeat (10) @(negedge odom_clk);
            chk("vec data", last_data, tv[i].exp_d);
            chk("vec err pulses", n_err - e0, tv[i].exp_err);
            chk("vec busy cleared", 32'(busy), 0);
            chk("vec single delivery", n_deliv - k0, 1);
`ifdef XDOM_DATA_RECEIVER_DROP_CNT_EN
            chk("vec drop cnt", 32'(dcnt), drops_total);
`endif
        end

        k0 = n_deliv;
        send(32'h1, 1); send(32'h2, 1); send(32'h3, 1);
        wait_deliv(k0 + 3);
        repeat (10) @(negedge odom_clk);
        chk("b2b count", n_deliv - k0, 3);
        chk("b2b last", last_data, 32'h3);

        set_ready(0);
        k0 = n_deliv; e0 = n_err;
        send(32'hA, 0);
        wait_idle();
        @(negedge odom_clk);
        chk("stall A valid", 32'(ovalid), 1);
        chk("stall A data", odata, 32'hA);
        send(32'hB, 0);
        repeat (40) @(negedge odom_clk);
        chk("stall busy held", 32'(busy), 1);
        chk("stall data held", odata, 32'hA);
        for (int j = 0; j < 300; j++) drop();
        repeat (10) @(negedge odom_clk);
        chk("300 err pulses", n_err - e0, 300);
        chk("stall no early delivery", n_deliv - k0, 0);
`ifdef XDOM_DATA_RECEIVER_DROP_CNT_EN
        chk("drop cnt saturates", 32'(dcnt), 255);
`endif
        set_ready(1);
        wait_deliv(k0 + 2);
        wait_idle();
        repeat (10) @(negedge odom_clk);
        chk("stall drained count", n_deliv - k0, 2);
        chk("stall drained last", last_data, 32'hB);

        set_ready(0);
        send(32'h99, 0);
        send(32'h77, 0);
        grst = 1;
        #1;
        chk("midreset busy", 32'(busy), 0);
        chk("midreset err", 32'(err), 0);
        chk("midreset valid", 32'(ovalid), 0);
        chk("midreset data", odata, 0);
        chk("midreset drop cnt", 32'(dcnt), 0);
        exp_q.delete();
        repeat (3) @(posedge xdom_clk);
        #1 grst = 0;
        set_ready(1);
        k0 = n_deliv;
        send(32'h55, 1);
        wait_deliv(k0 + 1);
        wait_idle();
        repeat (10) @(negedge odom_clk);
        chk("post reset count", n_deliv - k0, 1);
        chk("post reset data", last_data, 32'h55);

        oh = 135; xh = 50;
        repeat (4) @(posedge odom_clk);
        k0 = n_deliv; e0 = n_err; exp_drops = 0;
        rnd_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin rnd_mode = 0; set_ready(1); end
            repeat ($urandom_range(0, 2)) @(posedge xdom_clk);
            send($urandom, i > 500);
            if ($urandom_range(0, 7) == 0) begin drop(); exp_drops++; end
        end
        wait_deliv(k0 + 1000);
        wait_idle();
        repeat (10) @(negedge odom_clk);
        chk("random count", n_deliv - k0, 1000);
        chk("random queue empty", exp_q.size(), 0);
        chk("random err pulses", n_err - e0, exp_drops);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
